seven_segment_decoder: RTL and testbench

Captures a multiplexed seven-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the hex digits and decimal points it shows. The bus uses the team's seven-segment encoding: active-high segments `a..h`, and a lit dot inverts all eight segment bits. The block is a bench/monitor and loopback component: it sits on the pins driven by a display driver (or an external board) and presents a coherent number to scoreboards or a host. Inputs are treated as asynchronous, are glitch-filtered, and are committed one full frame at a time.

---
 rtl/seven_segment_decoder_if.sv | 31 +++
 rtl/seven_segment_decoder.sv | 182 ++++++++++++++++++
 tb/tb_seven_segment_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seven_segment_decoder_if                                   |
// | Brief   : Seven-segment display bus (segments + one-hot strobes) and |
// |           the reconstructed frame/status signals of its decoder.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface seven_segment_decoder_if #(
  parameter int W_DIGIT = 2
);
  logic [7:0]           abcdefgh;
  logic [W_DIGIT-1:0]   digit;
  logic [W_DIGIT*4-1:0] number;
  logic [W_DIGIT-1:0]   dots;
  logic                 frame_done;
  logic                 seg_err;
  logic                 strobe_err;

  // Display driver side: drives the pins, observes the decoded frame.
  modport master (
    output abcdefgh, digit,
    input  number, dots, frame_done, seg_err, strobe_err
  );

  // Decoder side: samples the pins, presents the decoded frame.
  modport slave (
    input  abcdefgh, digit,
    output number, dots, frame_done, seg_err, strobe_err
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seven_segment_decoder                                      |
// | Brief   : Captures a multiplexed seven-segment bus, glitch-filters   |
// |           it and commits whole frames of hex digits and dots.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module seven_segment_decoder #(
  parameter int W_DIGIT       = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  seven_segment_decoder_if.slave  bus
);

  localparam int               CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Reset release synchronizer: assertion is immediate, release is clocked.
  logic rst_meta;
  logic rst_sync_n;

  // Two-flop release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Synchronizer stages and the previous synchronized sample.
  logic [7:0]         seg_meta, s_seg, prev_seg;
  logic [W_DIGIT-1:0] dig_meta, s_dig, prev_dig;

  // Double-flop the asynchronous pins and keep last cycle's copy.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      seg_meta <= '0;
      s_seg    <= '0;
      prev_seg <= '0;
      dig_meta <= '0;
      s_dig    <= '0;
      prev_dig <= '0;
    end else begin
      seg_meta <= bus.abcdefgh;
      s_seg    <= seg_meta;
      prev_seg <= s_seg;
      dig_meta <= bus.digit;
      s_dig    <= dig_meta;
      prev_dig <= s_dig;
    end
  end

  // Stability tracking.
  logic [CNT_W-1:0] stab;
  logic             done;
  logic             changed;
  logic             capture;

  assign changed = ({s_seg, s_dig} != {prev_seg, prev_dig});
  assign capture = !changed && (stab == STAB_MAX) && !done;

  // Saturating dwell counter; done limits a long dwell to one capture.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      stab <= '0;
      done <= 1'b0;
    end else if (changed) begin
      stab <= '0;
      done <= 1'b0;
    end else begin
      if (stab != STAB_MAX) stab <= stab + 1'b1;
      if (capture)          done <= 1'b1;
    end
  end

  // Pattern decode: returns {valid, nibble}; dotted patterns are inverted first.
  function automatic logic [4:0] decode_pat(input logic [7:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      8'hFC: r = {1'b1, 4'h0};
      8'h60: r = {1'b1, 4'h1};
      8'hDA: r = {1'b1, 4'h2};
      8'hF2: r = {1'b1, 4'h3};
      8'h66: r = {1'b1, 4'h4};
      8'hB6: r = {1'b1, 4'h5};
      8'hBE: r = {1'b1, 4'h6};
      8'hE0: r = {1'b1, 4'h7};
      8'hFE: r = {1'b1, 4'h8};
      8'hE6: r = {1'b1, 4'h9};
      8'hEE: r = {1'b1, 4'hA};
      8'h3E: r = {1'b1, 4'hB};
      8'h9C: r = {1'b1, 4'hC};
      8'h7A: r = {1'b1, 4'hD};
      8'h9E: r = {1'b1, 4'hE};
      8'h8E: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic               dot;
  logic [7:0]         pat;
  logic [4:0]         dec;
  logic               blank;
  logic               multi;
  logic               good;
  logic               commit;
  logic [W_DIGIT-1:0] seen;
  logic [W_DIGIT-1:0] seen_next;

  assign dot       = s_seg[0];
  assign pat       = dot ? ~s_seg : s_seg;
  assign dec       = decode_pat(pat);
  assign blank     = (s_dig == '0);
  assign multi     = ((s_dig & (s_dig - 1'b1)) != '0);
  assign good      = capture && !blank && !multi && dec[4];
  assign seen_next = seen | s_dig;
  assign commit    = good && (&seen_next);

  // Shadow frame with the current capture merged in.
  logic [W_DIGIT*4-1:0] shadow_num, shadow_num_next;
  logic [W_DIGIT-1:0]   shadow_dot, shadow_dot_next;

  // Merge the decoded digit into the slot selected by the one-hot strobe.
  always_comb begin
    shadow_num_next = shadow_num;
    shadow_dot_next = shadow_dot;
    for (int i = 0; i < W_DIGIT; i++) begin
      if (s_dig[i]) begin
        shadow_num_next[4*i +: 4] = dec[3:0];
        shadow_dot_next[i]        = dot;
      end
    end
  end

  logic [W_DIGIT*4-1:0] number_q;
  logic [W_DIGIT-1:0]   dots_q;
  logic                 frame_done_q;
  logic                 seg_err_q;
  logic                 strobe_err_q;

  // Store valid captures, commit complete frames and raise status pulses.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      shadow_num   <= '0;
      shadow_dot   <= '0;
      seen         <= '0;
      number_q     <= '0;
      dots_q       <= '0;
      frame_done_q <= 1'b0;
      seg_err_q    <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      frame_done_q <= commit;
      seg_err_q    <= capture && !blank && !multi && !dec[4];
      strobe_err_q <= capture && multi;
      if (good) begin
        shadow_num <= shadow_num_next;
        shadow_dot <= shadow_dot_next;
        seen       <= commit ? '0 : seen_next;
      end
      if (commit) begin
        number_q <= shadow_num_next;
        dots_q   <= shadow_dot_next;
      end
    end
  end

  assign bus.number     = number_q;
  assign bus.dots       = dots_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seg_err    = seg_err_q;
  assign bus.strobe_err = strobe_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_seven_segment_decoder                                   |
// | Brief   : Directed and randomized checks of seven_segment_decoder    |
// |           against an encoder-table reference model.                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_seven_segment_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  seven_segment_decoder_if #(.W_DIGIT(2)) if2 ();
  seven_segment_decoder_if #(.W_DIGIT(4)) if4 ();

  seven_segment_decoder #(.W_DIGIT(2), .STABLE_CYCLES(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  seven_segment_decoder #(.W_DIGIT(4), .STABLE_CYCLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  // Segment patterns of hex digits 0..F, dot off.
  logic [7:0] tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int passed = 0;
  int total  = 0;
  int fd2 = 0, se2 = 0, st2 = 0, ov2 = 0;
  int fd4 = 0, se4 = 0, st4 = 0, ov4 = 0;

  // Pulse counters for both instances.
  always @(posedge clk) begin
    if (if2.frame_done === 1'b1) fd2++;
    if (if2.seg_err    === 1'b1) se2++;
    if (if2.strobe_err === 1'b1) st2++;
    if ((int'(if2.frame_done === 1'b1) + int'(if2.seg_err === 1'b1) + int'(if2.strobe_err === 1'b1)) > 1) ov2++;
    if (if4.frame_done === 1'b1) fd4++;
    if (if4.seg_err    === 1'b1) se4++;
    if (if4.strobe_err === 1'b1) st4++;
    if ((int'(if4.frame_done === 1'b1) + int'(if4.seg_err === 1'b1) + int'(if4.strobe_err === 1'b1)) > 1) ov4++;
  end

  // Encoder model: segments XOR dot.
  function automatic logic [7:0] enc(input logic [3:0] n, input logic d);
    return tab[n] ^ {8{d}};
  endfunction

  // Reverse lookup: digit index of a bus pattern, or -1 if undecodable.
  function automatic int lookup(input logic [7:0] b);
    logic [7:0] p;
    p = b[0] ? ~b : b;
    for (int i = 0; i < 16; i++) if (tab[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive2(input logic [1:0] d, input logic [7:0] s, input int n);
    if2.digit    = d;
    if2.abcdefgh = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive4(input logic [3:0] d, input logic [7:0] s, input int n);
    if4.digit    = d;
    if4.abcdefgh = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b_fd, b_se, b_st;
    logic [15:0] exp_num;
    logic [3:0]  exp_dot;
    logic [7:0]  rb;

    if2.digit = '0; if2.abcdefgh = '0;
    if4.digit = '0; if4.abcdefgh = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset number2", 32'(if2.number), 32'h0);
    chk("reset dots2", 32'(if2.dots), 32'h0);
    chk("reset flags2", 32'({if2.frame_done, if2.seg_err, if2.strobe_err}), 32'h0);
    chk("reset number4", 32'(if4.number), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame
    b_fd = fd2; b_se = se2; b_st = st2;
    drive2(2'b01, 8'hFC, 10);
    drive2(2'b10, 8'h0D, 10);
    drive2(2'b00, 8'h00, 10);
    chk("basic frames", 32'(fd2 - b_fd), 32'd1);
    chk("basic number", 32'(if2.number), 32'h30);
    chk("basic dots", 32'(if2.dots), 32'h2);
    chk("basic errors", 32'((se2 - b_se) + (st2 - b_st)), 32'd0);

    // Glitch reject: short pulses inside and at the end of the digit-0 dwell
    b_fd = fd2; b_se = se2; b_st = st2;
    drive2(2'b01, 8'hFC, 4);
    drive2(2'b01, 8'h60, 3);
    drive2(2'b01, 8'hFC, 10);
    drive2(2'b01, 8'h60, 3);
    drive2(2'b10, 8'h0D, 10);
    drive2(2'b00, 8'h00, 10);
    chk("glitch frames", 32'(fd2 - b_fd), 32'd1);
    chk("glitch number", 32'(if2.number), 32'h30);
    chk("glitch dots", 32'(if2.dots), 32'h2);
    chk("glitch errors", 32'((se2 - b_se) + (st2 - b_st)), 32'd0);

    // Multiple strobes
    b_fd = fd2; b_st = st2;
    drive2(2'b11, 8'hFC, 10);
    drive2(2'b00, 8'h00, 10);
    chk("strobe_err count", 32'(st2 - b_st), 32'd1);
    chk("strobe_err no frame", 32'(fd2 - b_fd), 32'd0);
    chk("strobe_err number", 32'(if2.number), 32'h30);

    // 01 on the bus is a dotted 8
    b_fd = fd2; b_se = se2;
    drive2(2'b01, 8'h01, 10);
    drive2(2'b10, 8'hFC, 10);
    drive2(2'b00, 8'h00, 10);
    chk("dot8 frames", 32'(fd2 - b_fd), 32'd1);
    chk("dot8 number", 32'(if2.number), 32'h08);
    chk("dot8 dots", 32'(if2.dots), 32'h1);
    chk("dot8 seg_err", 32'(se2 - b_se), 32'd0);

    // Undecodable pattern
    b_fd = fd2; b_se = se2;
    drive2(2'b01, 8'h02, 10);
    drive2(2'b00, 8'h00, 10);
    chk("seg_err count", 32'(se2 - b_se), 32'd1);
    chk("seg_err no frame", 32'(fd2 - b_fd), 32'd0);
    chk("seg_err number", 32'(if2.number), 32'h08);

    // Long dwell then completion
    b_fd = fd2; b_se = se2; b_st = st2;
    drive2(2'b01, 8'h60, 100);
    drive2(2'b00, 8'h00, 10);
    chk("long dwell no frame", 32'(fd2 - b_fd), 32'd0);
    drive2(2'b10, 8'hDA, 10);
    drive2(2'b00, 8'h00, 10);
    chk("long dwell frames", 32'(fd2 - b_fd), 32'd1);
    chk("long dwell number", 32'(if2.number), 32'h21);
    chk("long dwell errors", 32'((se2 - b_se) + (st2 - b_st)), 32'd0);

    // Slot rewritten before commit keeps the latest value
    b_fd = fd2;
    drive2(2'b01, 8'h60, 10);
    drive2(2'b01, 8'hDA, 10);
    drive2(2'b10, 8'hFC, 10);
    drive2(2'b00, 8'h00, 10);
    chk("rewrite frames", 32'(fd2 - b_fd), 32'd1);
    chk("rewrite number", 32'(if2.number), 32'h02);

    // Reset mid-frame
    drive2(2'b01, 8'hB6, 10);
    if2.digit = '0; if2.abcdefgh = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset number", 32'(if2.number), 32'h0);
    chk("async reset dots", 32'(if2.dots), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    b_fd = fd2;
    drive2(2'b10, 8'h66, 10);
    drive2(2'b00, 8'h00, 10);
    chk("post-reset partial frame", 32'(fd2 - b_fd), 32'd0);
    chk("post-reset number", 32'(if2.number), 32'h0);
    drive2(2'b01, 8'hB6, 10);
    drive2(2'b00, 8'h00, 10);
    chk("post-reset full frame", 32'(fd2 - b_fd), 32'd1);
    chk("post-reset number full", 32'(if2.number), 32'h45);

    // Sweep of every nibble and dot in every position, others random
    for (int k = 0; k < 128; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_num[4*j +: 4] = 4'($urandom_range(15));
        exp_dot[j]        = 1'($urandom_range(1));
      end
      exp_num[4*(k/32) +: 4] = 4'((k / 2) % 16);
      exp_dot[k/32]          = 1'(k % 2);
      b_fd = fd4;
      for (int j = 0; j < 4; j++)
        drive4(4'(1 << j), enc(exp_num[4*j +: 4], exp_dot[j]), 9);
      chk("sweep number", 32'(if4.number), 32'(exp_num));
      chk("sweep dots", 32'(if4.dots), 32'(exp_dot));
      chk("sweep frames", 32'(fd4 - b_fd), 32'd1);
    end
    drive4(4'b0000, 8'h00, 10);

    // Random patterns on one slot: classify via the table
    b_fd = fd4;
    for (int k = 0; k < 24; k++) begin
      rb   = 8'($urandom);
      b_se = se4;
      drive4(4'b0001, rb, 9);
      drive4(4'b0000, 8'h00, 3);
      chk("random pattern seg_err", 32'(se4 - b_se), (lookup(rb) < 0) ? 32'd1 : 32'd0);
    end
    chk("random no frame", 32'(fd4 - b_fd), 32'd0);
    chk("random strobe_err", 32'(st4), 32'd0);

    chk("pulse exclusivity 2", 32'(ov2), 32'd0);
    chk("pulse exclusivity 4", 32'(ov4), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
